// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined bitwise logic unit with OR accumulator
// Purpose: selects one of eight bitwise functions per transaction, registers the
//    result with zero/parity flags, and moves data through a valid/ready pipeline.
// Ports:
//    clk        rising-edge clock
//    rst        asynchronous active-high reset
//    in_valid   operand transaction valid
//    in_ready   unit can accept a transaction this cycle
//    in_a/in_b  operands (WIDTH bits)
//    in_op      function select: AND OR NOR NAND XOR XNOR NOTA ACC
//    acc_clr    accumulator clear sideband, sampled every cycle
//    out_valid  result valid
//    out_ready  downstream accepts result
//    out_y      result (WIDTH bits)
//    out_zero   out_y == 0
//    out_par    XOR reduction of out_y
module logic_unit_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_par
);

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NOR  = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_NOTA = 3'd6;
   localparam logic [2:0] OP_ACC  = 3'd7;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [2:0]       r_s1_op;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_y;
   logic             r_zero;
   logic             r_par;
   logic [WIDTH-1:0] r_acc;

   logic             w_s2_adv;
   logic             w_s1_adv;
   logic             w_accept;
   logic             w_acc_move;
   logic [WIDTH-1:0] w_acc_base;
   logic [WIDTH-1:0] w_y;

   assign w_s2_adv   = ~r_s2_valid | out_ready;
   assign w_s1_adv   = r_s1_valid & w_s2_adv;
   assign in_ready   = ~r_s1_valid | w_s2_adv;
   assign w_accept   = in_valid & in_ready;
   assign w_acc_move = w_s1_adv & (r_s1_op == OP_ACC);
   // A clear landing on the same edge as an ACC move makes the old value count as zero.
   assign w_acc_base = acc_clr ? '0 : r_acc;

   always_comb begin
      w_y = '0;
      case (r_s1_op)
         OP_AND:  w_y = r_s1_a & r_s1_b;
         OP_OR:   w_y = r_s1_a | r_s1_b;
         OP_NOR:  w_y = ~(r_s1_a | r_s1_b);
         OP_NAND: w_y = ~(r_s1_a & r_s1_b);
         OP_XOR:  w_y = r_s1_a ^ r_s1_b;
         OP_XNOR: w_y = ~(r_s1_a ^ r_s1_b);
         OP_NOTA: w_y = ~r_s1_a;
         default: w_y = w_acc_base | r_s1_a | r_s1_b;
      endcase
   end

   // Stage 1: operand capture. Empties when it hands off and nothing new arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= '0;
      end else begin
         if (in_ready) begin
            r_s1_valid <= in_valid;
         end
         if (w_accept) begin
            r_s1_a  <= in_a;
            r_s1_b  <= in_b;
            r_s1_op <= in_op;
         end
      end
   end

   // Stage 2: result register; holds while the downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_y        <= '0;
         r_zero     <= 1'b0;
         r_par      <= 1'b0;
      end else begin
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s1_adv) begin
            r_y    <= w_y;
            r_zero <= ~|w_y;
            r_par  <= ^w_y;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (w_acc_move) begin
         r_acc <= w_y;
      end else if (acc_clr) begin
         r_acc <= '0;
      end
   end

   assign out_valid = r_s2_valid;
   assign out_y     = r_y;
   assign out_zero  = r_zero;
   assign out_par   = r_par;

endmodule
